reorder_buffer: RTL

//  Circular in-order reorder buffer for the out-of-order RV32I core; the producer end of the register-file rename interface.

---
 rtl/reorder_buffer_pkg.sv | 10 +
 rtl/reorder_buffer_query_port.sv | 25 ++
 rtl/reorder_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared tag width and entry-type encodings for the reorder buffer.
package reorder_buffer_pkg;
   localparam int ROB_WIDTH_BIT = 4;

   typedef enum logic [1:0] {
      ROB_TYPE_REG    = 2'd0,
      ROB_TYPE_STORE  = 2'd1,
      ROB_TYPE_BRANCH = 2'd2
   } rob_type_e;
endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup for one register-file read: stored entry value, with the
// CDB broadcast bypassing it when the tags match.
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int W = ROB_WIDTH_BIT
) (
   input  logic [W-1:0]        tag_i,
   input  logic [(1<<W)-1:0]   busy_i,
   input  logic [(1<<W)-1:0]   ready_i,
   input  logic [31:0]         val_i [1<<W],
   input  logic                cdb_valid_i,
   input  logic [W-1:0]        cdb_rob_id_i,
   input  logic [31:0]         cdb_val_i,
   output logic                ready_o,
   output logic [31:0]         value_o
);
   logic bypass;

   always_comb begin
      bypass  = cdb_valid_i && (cdb_rob_id_i == tag_i);
      ready_o = bypass || (busy_i[tag_i] && ready_i[tag_i]);
      value_o = bypass ? cdb_val_i : val_i[tag_i];
   end
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, operand
// queries and single-entry commit. Define ROB_STAT_EN for commit/flush counters.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int W = ROB_WIDTH_BIT
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          issue_valid,
   input  logic [1:0]    issue_type,
   input  logic [4:0]    issue_rd,
   input  logic          issue_ready,
   input  logic [31:0]   issue_val,
   input  logic [31:0]   issue_pc,
   input  logic          issue_pred_taken,
   output logic          full,
   output logic [W-1:0]  issue_rob_id,
   output logic [4:0]    set_dep_reg_id,
   output logic [W-1:0]  set_dep_rob_id,
   input  logic          cdb_valid,
   input  logic [W-1:0]  cdb_rob_id,
   input  logic [31:0]   cdb_val,
   input  logic          cdb_taken,
   input  logic [31:0]   cdb_target,
   input  logic [W-1:0]  get_rob_id1,
   input  logic [W-1:0]  get_rob_id2,
   output logic          rob_value1_ready,
   output logic [31:0]   rob_value1,
   output logic          rob_value2_ready,
   output logic [31:0]   rob_value2,
   output logic [4:0]    set_reg_id,
   output logic [31:0]   set_val,
   output logic [W-1:0]  set_reg_on_rob_id,
   output logic          store_commit,
   output logic [W-1:0]  head_rob_id,
   output logic          rob_clear,
`ifdef ROB_STAT_EN
   output logic [31:0]   stat_commit_cnt,
   output logic [31:0]   stat_flush_cnt,
`endif
   output logic [31:0]   clear_pc
);
   localparam int DEPTH = 1 << W;

   logic [W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [W:0]     count_q, count_d;
   logic [DEPTH-1:0] busy_q, ready_q, pred_q, taken_q;
   rob_type_e      type_q   [DEPTH];
   logic [4:0]     rd_q     [DEPTH];
   logic [31:0]    val_q    [DEPTH];
   logic [31:0]    pc_q     [DEPTH];
   logic [31:0]    target_q [DEPTH];

   logic commit, issue_accept, cdb_hit;

   always_comb begin
      full         = (count_q == (W+1)'(DEPTH));
      commit       = rdy_in && (count_q != '0) && busy_q[head_q] && ready_q[head_q];
      rob_clear    = commit && (type_q[head_q] == ROB_TYPE_BRANCH) &&
                     (taken_q[head_q] != pred_q[head_q]);
      issue_accept = rdy_in && issue_valid && !full && !rob_clear;
      cdb_hit      = rdy_in && cdb_valid && busy_q[cdb_rob_id] && !rob_clear;

      set_reg_id   = (commit && type_q[head_q] == ROB_TYPE_REG) ? rd_q[head_q] : 5'd0;
      set_val      = commit ? val_q[head_q] : 32'd0;
      store_commit = commit && (type_q[head_q] == ROB_TYPE_STORE);
      clear_pc     = '0;
      if (rob_clear)
         clear_pc = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;

      set_dep_reg_id = (rdy_in && issue_valid && issue_type == ROB_TYPE_REG) ? issue_rd : 5'd0;
      set_dep_rob_id    = tail_q;
      issue_rob_id      = tail_q;
      set_reg_on_rob_id = head_q;
      head_rob_id       = head_q;

      head_d  = head_q + W'(commit);
      tail_d  = tail_q + W'(issue_accept);
      count_d = count_q + (W+1)'(issue_accept) - (W+1)'(commit);
      if (rob_clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         ready_q <= '0;
         pred_q  <= '0;
         taken_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            type_q[i]   <= ROB_TYPE_REG;
            rd_q[i]     <= '0;
            val_q[i]    <= '0;
            pc_q[i]     <= '0;
            target_q[i] <= '0;
         end
      end else if (rdy_in) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (rob_clear) begin
            busy_q  <= '0;
            ready_q <= '0;
         end else begin
            if (commit) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
            end
            if (issue_accept) begin
               busy_q[tail_q]   <= 1'b1;
               ready_q[tail_q]  <= issue_ready;
               type_q[tail_q]   <= rob_type_e'(issue_type);
               rd_q[tail_q]     <= issue_rd;
               val_q[tail_q]    <= issue_val;
               pc_q[tail_q]     <= issue_pc;
               pred_q[tail_q]   <= issue_pred_taken;
               taken_q[tail_q]  <= 1'b0;
               target_q[tail_q] <= '0;
            end
            // Only busy tags capture; a tag allocated this cycle is not yet busy.
            if (cdb_hit) begin
               ready_q[cdb_rob_id]  <= 1'b1;
               val_q[cdb_rob_id]    <= cdb_val;
               taken_q[cdb_rob_id]  <= cdb_taken;
               target_q[cdb_rob_id] <= cdb_target;
            end
         end
      end
   end

`ifdef ROB_STAT_EN
   logic [31:0] commit_cnt_q, flush_cnt_q;
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         commit_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (commit)    commit_cnt_q <= commit_cnt_q + 32'd1;
         if (rob_clear) flush_cnt_q  <= flush_cnt_q + 32'd1;
      end
   end
   assign stat_commit_cnt = commit_cnt_q;
   assign stat_flush_cnt  = flush_cnt_q;
`endif

   rob_query_port #(.W(W)) u_query1 (
      .tag_i(get_rob_id1), .busy_i(busy_q), .ready_i(ready_q), .val_i(val_q),
      .cdb_valid_i(cdb_valid), .cdb_rob_id_i(cdb_rob_id), .cdb_val_i(cdb_val),
      .ready_o(rob_value1_ready), .value_o(rob_value1)
   );

   rob_query_port #(.W(W)) u_query2 (
      .tag_i(get_rob_id2), .busy_i(busy_q), .ready_i(ready_q), .val_i(val_q),
      .cdb_valid_i(cdb_valid), .cdb_rob_id_i(cdb_rob_id), .cdb_val_i(cdb_val),
      .ready_o(rob_value2_ready), .value_o(rob_value2)
   );
endmodule
